wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 3-stage RISC-V core. It sits between the execute/memory stage and the register file. It registers one retiring instruction, waits for a data-memory response on loads, and aligns and sign-extends load data. It drives the register-file write port (we/rd/wd) and publishes forwarding and load-hazard information back to execute, plus a retired-instruction counter for the CSR block.

## Interface
Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ex_valid  in  1  execute presents a retiring instruction.
- ex_ready  out  1  stage accepts it this cycle.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_we  in  1  instruction writes rd.
- ex_wb_sel  in  2  result source: 0 = ALU, 1 = LOAD, 2 = PC+4; 3 is reserved and treated as ALU.
- ex_alu_result  in  XLEN  ALU result, or load byte address on loads.
- ex_pc4  in  XLEN  PC+4.
- ex_funct3  in  3  load width: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  aligned 32-bit word.
- rf_we  out  1  register-file write enable.
- rf_rd  out  REG_ADDR_W  register-file write index.
- rf_wd  out  XLEN  register-file write data.
- fwd_valid  out  1  fwd_rd/fwd_data hold a usable bypass value this cycle.
- fwd_rd  out  REG_ADDR_W  bypass register index.
- fwd_data  out  XLEN  bypass value.
- load_pending  out  1  a load to fwd_rd is outstanding; execute must stall on a match.
- load_misaligned  out  1  one-cycle pulse for a misaligned load.
- instret  out  64  retired-instruction count.

## Operation
- States: EMPTY, RESULT, WAIT_LOAD.
- Accept: on a posedge with ex_valid && ex_ready, capture rd, we, wb_sel, alu_result, pc4, funct3. Next state is WAIT_LOAD for loads; otherwise RESULT.
- ex_ready = (state != WAIT_LOAD) || dmem_rvalid. The stage never stalls except while waiting for load data.
- RESULT:
  - rf_we = we && rd != 0.
  - rf_wd = pc4 if wb_sel = 2, else alu_result.
  - The instruction retires this cycle.
  - Next state is EMPTY unless a new instruction is accepted.
- WAIT_LOAD:
  - load_pending = we && rd != 0.
  - When dmem_rvalid = 1: rf_we = we && rd != 0, rf_wd = extracted load data, and the instruction retires this cycle.
  - While dmem_rvalid = 0: the state holds and rf_we = 0.
- Load extract:
  - off = alu_result[1:0]; lane = dmem_rdata >> (8*off).
  - LB/LH sign-extend lane[7:0] / lane[15:0].
  - LBU/LHU zero-extend them.
  - LW passes the word through.
  - Any other funct3 is treated as LW.
- Misaligned load (LH/LHU with off[0] = 1, or LW with off != 0):
  - Never enters WAIT_LOAD.
  - Goes to RESULT with the write suppressed (rf_we = 0).
  - load_misaligned pulses in that RESULT cycle.
  - Counts as retired.
- Forwarding:
  - fwd_valid = rf_we; fwd_rd = rf_rd; fwd_data = rf_wd.
  - fwd_valid is never asserted for rd = 0.
- instret: increments by 1 on every retire cycle (RESULT, or WAIT_LOAD with dmem_rvalid). It wraps at 2^64.
- dmem_rvalid outside WAIT_LOAD is ignored.

## Timing
- Reset (async assert, sync release): state = EMPTY; all captured fields = 0; instret = 0. All outputs are 0 except ex_ready = 1.
- Non-load latency: accepted at edge N; rf_we is high during cycle N+1; the register file writes at edge N+1.
- Load latency: the write occurs in the same cycle dmem_rvalid is high. The earliest case is the cycle after acceptance.
- Back-to-back: a new instruction can be accepted at the same edge the current one retires. Throughput is 1 per cycle without loads.
- Simultaneous: dmem_rvalid together with ex_valid completes the load and accepts the next instruction on the same edge.
- rst asserted mid-load returns the stage to EMPTY. The pending response is dropped with no write and no instret increment.
- All rf_*/fwd_* outputs are combinational from state and registers, plus dmem_rvalid/dmem_rdata in WAIT_LOAD. There is no path from ex_* inputs.

## Structure
- Shared package/defines:
  - XLEN and REG_FILE_ADDR_WIDTH (already in defines.v).
  - WB_SEL_ALU/LOAD/PC4 encodings.
  - LB/LH/LW/LBU/LHU funct3 constants.
  - wb state encodings.
- Sub-module load_align: purely combinational (rdata, off, funct3) -> (data, misaligned). It is reused by any future unaligned-access logic.

## Test plan
- Reset, then ALU op with rd = 5, alu_result = 0x1234 -> one cycle later rf_we = 1, rf_rd = 5, rf_wd = 0x1234, instret = 1.
- LB at address 0x103 with dmem_rdata = 0x80FF_0000 after 3 wait cycles -> ex_ready = 0 and load_pending = 1 for 3 cycles, then rf_wd = 0xFFFF_FF80. A repeat with LBU -> rf_wd = 0x0000_0080.
- LW at address 0x102 -> load_misaligned pulses, rf_we = 0, instret increments.
- Write to rd = 0 (ALU and load) -> rf_we = 0 and fwd_valid = 0, but instret still increments.
- dmem_rvalid and ex_valid in the same cycle (LHU at off 2 with rdata 0xBEEF_0000, then PC+4 op with pc4 = 0x40) -> rf_wd = 0x0000_BEEF, then rf_wd = 0x40 on the next cycle.
- rst driven low while in WAIT_LOAD -> immediately EMPTY and instret = 0; a later dmem_rvalid causes no write.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load widths,
// FSM states and the load misalignment rule.
package wb_stage_pkg;

   localparam int XLEN                = 32;
   localparam int REG_FILE_ADDR_WIDTH = 5;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_EMPTY     = 2'd0,
      WB_RESULT    = 2'd1,
      WB_WAIT_LOAD = 2'd2
   } wb_state_e;

   // Unlisted funct3 codes behave as LW, so they share the word alignment rule.
   function automatic logic load_is_misaligned(input logic [1:0] off, input logic [2:0] funct3);
      logic w_mis;
      case (funct3)
         F3_LB, F3_LBU: w_mis = 1'b0;
         F3_LH, F3_LHU: w_mis = off[0];
         default:       w_mis = (off != 2'b00);
      endcase
      return w_mis;
   endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load lane selection and sign/zero extension from an aligned word.
module wb_stage_load_align
   import wb_stage_pkg::*;
#(
   parameter int XLEN_P = 32
) (
   input  logic [XLEN_P-1:0] i_rdata,
   input  logic [1:0]        i_off,
   input  logic [2:0]        i_funct3,
   output logic [XLEN_P-1:0] o_data,
   output logic              o_misaligned
);

   logic [XLEN_P-1:0] w_lane;

   assign w_lane       = i_rdata >> {i_off, 3'b000};
   assign o_misaligned = load_is_misaligned(i_off, i_funct3);

   always_comb begin
      o_data = i_rdata;
      case (i_funct3)
         F3_LB:   o_data = {{(XLEN_P-8){w_lane[7]}}, w_lane[7:0]};
         F3_LH:   o_data = {{(XLEN_P-16){w_lane[15]}}, w_lane[15:0]};
         F3_LBU:  o_data = {{(XLEN_P-8){1'b0}}, w_lane[7:0]};
         F3_LHU:  o_data = {{(XLEN_P-16){1'b0}}, w_lane[15:0]};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers one retiring instruction, waits for load data,
// drives the register-file write port, forwarding info and the retire counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN       = wb_stage_pkg::XLEN,
   parameter int REG_ADDR_W = REG_FILE_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_we,
   input  logic [1:0]            ex_wb_sel,
   input  logic [XLEN-1:0]       ex_alu_result,
   input  logic [XLEN-1:0]       ex_pc4,
   input  logic [2:0]            ex_funct3,
   input  logic                  dmem_rvalid,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wd,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]       fwd_data,
   output logic                  load_pending,
   output logic                  load_misaligned,
   output logic [63:0]           instret,
   output logic [1:0]            dbg_state
);

   wb_state_e             r_state;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_we;
   logic [1:0]            r_wb_sel;
   logic [XLEN-1:0]       r_alu;
   logic [XLEN-1:0]       r_pc4;
   logic [2:0]            r_funct3;
   logic                  r_misaligned;
   logic [63:0]           r_instret;

   logic                  w_accept;
   logic                  w_ex_is_load;
   logic                  w_ex_mis;
   logic                  w_retire;
   logic                  w_rd_live;
   logic [XLEN-1:0]       w_load_data;
   logic                  w_load_mis_unused;

   wb_stage_load_align #(.XLEN_P(XLEN)) u_align (
      .i_rdata      (dmem_rdata),
      .i_off        (r_alu[1:0]),
      .i_funct3     (r_funct3),
      .o_data       (w_load_data),
      .o_misaligned (w_load_mis_unused)
   );

   assign ex_ready     = (r_state != WB_WAIT_LOAD) || dmem_rvalid;
   assign w_accept     = ex_valid && ex_ready;
   assign w_ex_is_load = (ex_wb_sel == WB_SEL_LOAD);
   assign w_ex_mis     = w_ex_is_load && load_is_misaligned(ex_alu_result[1:0], ex_funct3);

   assign w_retire  = (r_state == WB_RESULT) || ((r_state == WB_WAIT_LOAD) && dmem_rvalid);
   assign w_rd_live = r_we && (r_rd != '0);

   // A misaligned load retires through RESULT with its write suppressed.
   assign rf_we = w_retire && w_rd_live && !((r_state == WB_RESULT) && r_misaligned);
   assign rf_rd = r_rd;

   always_comb begin
      rf_wd = r_alu;
      if (r_state == WB_WAIT_LOAD)
         rf_wd = w_load_data;
      else if (r_wb_sel == WB_SEL_PC4)
         rf_wd = r_pc4;
   end

   assign fwd_valid       = rf_we;
   assign fwd_rd          = rf_rd;
   assign fwd_data        = rf_wd;
   assign load_pending    = (r_state == WB_WAIT_LOAD) && w_rd_live;
   assign load_misaligned = (r_state == WB_RESULT) && r_misaligned;
   assign instret         = r_instret;
   assign dbg_state       = r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= WB_EMPTY;
         r_rd         <= '0;
         r_we         <= 1'b0;
         r_wb_sel     <= WB_SEL_ALU;
         r_alu        <= '0;
         r_pc4        <= '0;
         r_funct3     <= 3'b000;
         r_misaligned <= 1'b0;
         r_instret    <= 64'd0;
      end else begin
         if (w_retire)
            r_instret <= r_instret + 64'd1;

         if (w_accept) begin
            r_rd         <= ex_rd;
            r_we         <= ex_we;
            r_wb_sel     <= ex_wb_sel;
            r_alu        <= ex_alu_result;
            r_pc4        <= ex_pc4;
            r_funct3     <= ex_funct3;
            r_misaligned <= w_ex_mis;
            r_state      <= (w_ex_is_load && !w_ex_mis) ? WB_WAIT_LOAD : WB_RESULT;
         end else begin
            case (r_state)
               WB_RESULT:    r_state <= WB_EMPTY;
               WB_WAIT_LOAD: if (dmem_rvalid) r_state <= WB_EMPTY;
               default:      r_state <= r_state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors checked with immediate assertions.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_rd;
   logic        ex_we;
   logic [1:0]  ex_wb_sel;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_pc4;
   logic [2:0]  ex_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        load_pending;
   logic        load_misaligned;
   logic [63:0] instret;
   logic [1:0]  dbg_state;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   wb_stage dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_rd           (ex_rd),
      .ex_we           (ex_we),
      .ex_wb_sel       (ex_wb_sel),
      .ex_alu_result   (ex_alu_result),
      .ex_pc4          (ex_pc4),
      .ex_funct3       (ex_funct3),
      .dmem_rvalid     (dmem_rvalid),
      .dmem_rdata      (dmem_rdata),
      .rf_we           (rf_we),
      .rf_rd           (rf_rd),
      .rf_wd           (rf_wd),
      .fwd_valid       (fwd_valid),
      .fwd_rd          (fwd_rd),
      .fwd_data        (fwd_data),
      .load_pending    (load_pending),
      .load_misaligned (load_misaligned),
      .instret         (instret),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change 1ns after the active edge; outputs are checked there too
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
      ex_valid      = 1'b1;
      ex_rd         = rd;
      ex_we         = we;
      ex_wb_sel     = sel;
      ex_alu_result = alu;
      ex_pc4        = pc4;
      ex_funct3     = f3;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      ex_valid = 1'b0; ex_rd = '0; ex_we = 1'b0; ex_wb_sel = '0;
      ex_alu_result = '0; ex_pc4 = '0; ex_funct3 = '0;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
      #2;
      check("rst_ex_ready", ex_ready, 1);
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_wd", rf_wd, 0);
      check("rst_fwd_valid", fwd_valid, 0);
      check("rst_load_pending", load_pending, 0);
      check("rst_instret", instret, 0);
      check("rst_state", dbg_state, WB_EMPTY);
      step();
      rst = 1'b1;
      step();

      // ALU op, rd=5
      drive_ex(5'd5, 1'b1, WB_SEL_ALU, 32'h1234, 32'h0, 3'b000);
      step(); idle_ex();
      check("alu_rf_we", rf_we, 1);
      check("alu_rf_rd", rf_rd, 5);
      check("alu_rf_wd", rf_wd, 32'h1234);
      check("alu_fwd_valid", fwd_valid, 1);
      check("alu_fwd_data", fwd_data, 32'h1234);
      step();
      check("alu_instret", instret, 1);
      check("alu_empty", dbg_state, WB_EMPTY);
      check("alu_empty_we", rf_we, 0);

      // LB at 0x103, three wait cycles, then 0x80FF_0000
      drive_ex(5'd7, 1'b1, WB_SEL_LOAD, 32'h103, 32'h0, F3_LB);
      step(); idle_ex();
      for (int i = 0; i < 3; i++) begin
         check("lb_wait_ready", ex_ready, 0);
         check("lb_wait_pending", load_pending, 1);
         check("lb_wait_we", rf_we, 0);
         step();
      end
      dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
      #1;
      check("lb_rf_we", rf_we, 1);
      check("lb_rf_rd", rf_rd, 7);
      check("lb_rf_wd", rf_wd, 32'hFFFF_FF80);
      check("lb_ready", ex_ready, 1);
      step(); dmem_rvalid = 1'b0;
      check("lb_instret", instret, 2);

      // LBU repeat
      drive_ex(5'd7, 1'b1, WB_SEL_LOAD, 32'h103, 32'h0, F3_LBU);
      step(); idle_ex();
      check("lbu_pending", load_pending, 1);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
      #1;
      check("lbu_rf_wd", rf_wd, 32'h0000_0080);
      step(); dmem_rvalid = 1'b0;
      check("lbu_instret", instret, 3);

      // LH sign extension from upper half
      drive_ex(5'd12, 1'b1, WB_SEL_LOAD, 32'h2, 32'h0, F3_LH);
      step(); idle_ex();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
      #1;
      check("lh_rf_wd", rf_wd, 32'hFFFF_8001);
      step(); dmem_rvalid = 1'b0;

      // LW at 0x102 is misaligned
      drive_ex(5'd8, 1'b1, WB_SEL_LOAD, 32'h102, 32'h0, F3_LW);
      step(); idle_ex();
      check("lwmis_state", dbg_state, WB_RESULT);
      check("lwmis_pulse", load_misaligned, 1);
      check("lwmis_rf_we", rf_we, 0);
      check("lwmis_ready", ex_ready, 1);
      step();
      check("lwmis_pulse_end", load_misaligned, 0);
      check("lwmis_instret", instret, 5);

      // rd = 0 writes are suppressed but retire
      drive_ex(5'd0, 1'b1, WB_SEL_ALU, 32'hDEAD, 32'h0, 3'b000);
      step(); idle_ex();
      check("x0_alu_we", rf_we, 0);
      check("x0_alu_fwd", fwd_valid, 0);
      step();
      check("x0_alu_instret", instret, 6);
      drive_ex(5'd0, 1'b1, WB_SEL_LOAD, 32'h100, 32'h0, F3_LW);
      step(); idle_ex();
      check("x0_ld_pending", load_pending, 0);
      check("x0_ld_ready", ex_ready, 0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
      #1;
      check("x0_ld_we", rf_we, 0);
      check("x0_ld_fwd", fwd_valid, 0);
      step(); dmem_rvalid = 1'b0;
      check("x0_ld_instret", instret, 7);

      // load response coinciding with the next accept
      drive_ex(5'd9, 1'b1, WB_SEL_LOAD, 32'h202, 32'h0, F3_LHU);
      step();
      dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
      drive_ex(5'd10, 1'b1, WB_SEL_PC4, 32'h999, 32'h40, 3'b000);
      #1;
      check("sim_lhu_we", rf_we, 1);
      check("sim_lhu_wd", rf_wd, 32'h0000_BEEF);
      check("sim_ready", ex_ready, 1);
      step(); dmem_rvalid = 1'b0; idle_ex();
      check("sim_pc4_state", dbg_state, WB_RESULT);
      check("sim_pc4_rd", rf_rd, 10);
      check("sim_pc4_wd", rf_wd, 32'h40);
      check("sim_pc4_instret", instret, 8);
      step();
      check("sim_final_instret", instret, 9);

      // reset while waiting for load data
      drive_ex(5'd11, 1'b1, WB_SEL_LOAD, 32'h0, 32'h0, F3_LB);
      step(); idle_ex();
      check("rstld_pending", load_pending, 1);
      #2 rst = 1'b0;
      #1;
      check("rstld_state", dbg_state, WB_EMPTY);
      check("rstld_instret", instret, 0);
      check("rstld_ready", ex_ready, 1);
      check("rstld_pending_clr", load_pending, 0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_00AA;
      #1;
      check("rstld_no_we", rf_we, 0);
      step();
      rst = 1'b1;
      #1;
      check("rstld_released_we", rf_we, 0);
      step();
      check("rstld_late_instret", instret, 0);
      check("rstld_late_state", dbg_state, WB_EMPTY);
      dmem_rvalid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
